gray_conv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one binary-to-Gray conversion datapath among several requesters. Each requester presents a binary word with a valid/ready handshake. The block grants one requester at a time, converts the word, and presents the registered Gray result with the requester's ID on a single valid/ready output port. It sits between the requesting units and any Gray-code consumer, such as a CDC pointer path or an encoder output stage.

---
 rtl/gray_conv_arbiter_if.sv | 39 +++
 rtl/gray_conv_arbiter.sv | 147 ++++++++++++++
 tb/tb_gray_conv_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if
//
// Bundles the requester side and the result side of the shared
// binary-to-Gray converter.
//
//   req_valid [N_REQ]        : requester i has a word pending
//   req_data  [N_REQ*WIDTH]  : requester i's word at [i*WIDTH +: WIDTH]
//   req_ready [N_REQ]        : one-hot (or zero) accept strobe
//   out_valid                : out_gray/out_id hold a result
//   out_gray  [WIDTH]        : registered Gray code of the accepted word
//   out_id    [ID_W]         : requester that produced out_gray
//   out_ready                : consumer takes the result
//
// master : the requesters plus the consumer (drives valid/data/out_ready)
// slave  : the arbiter itself
interface gray_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_gray;
  logic [ID_W-1:0]        out_id;
  logic                   out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_gray, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_gray, out_id
  );
endinterface

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//
// Round-robin arbiter that shares one binary-to-Gray converter among N_REQ
// requesters. In IDLE the first valid requester at or after the round-robin
// pointer is accepted combinationally; its word is converted and registered,
// and the block sits in BUSY presenting the result until the consumer takes
// it. The pointer then moves to the slot after the one just served.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : gray_conv_arbiter_if slave modport (request and result handshakes)
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  gray_conv_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;
  logic              out_valid_reg, out_valid_next;
  logic [WIDTH-1:0]  out_gray_reg, out_gray_next;
  logic [ID_W-1:0]   out_id_reg, out_id_next;

  logic [WIDTH-1:0]  req_word [N_REQ];
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand_id;
  int                cand;
  logic [WIDTH-1:0]  grant_word;
  logic [WIDTH-1:0]  grant_gray;
  logic              grant_en;
  logic [N_REQ-1:0]  ready_vec;
  logic [ID_W-1:0]   ptr_after;

  // Unpack the flat data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_word[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Priority search starting at ptr, wrapping modulo N_REQ. Only the first
  // hit is kept, so later candidates never override an earlier one.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = 0;
    cand_id     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_id = cand[ID_W-1:0];
      if (!grant_found && bus.req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_id    = cand_id;
      end
    end
  end

  assign grant_word = req_word[grant_id];

  // Gray conversion: MSB passes through, every lower bit is the XOR of
  // itself with its upper neighbour.
  assign grant_gray[WIDTH-1] = grant_word[WIDTH-1];
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign grant_gray[gi] = grant_word[gi+1] ^ grant_word[gi];
    end
  endgenerate

  // Accept strobe: only in IDLE, never while reset is asserted.
  assign grant_en = (state_reg == IDLE) && grant_found && !rst;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign ready_vec[gi] = grant_en && (grant_id == ID_W'(gi));
    end
  endgenerate

  assign bus.req_ready = ready_vec;

  // Slot after the one just served; N_REQ need not be a power of two, so
  // the wrap is explicit rather than relying on counter overflow.
  assign ptr_after = (out_id_reg == ID_W'(N_REQ - 1)) ? '0 : out_id_reg + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_gray_reg  <= '0;
      out_id_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      out_valid_reg <= out_valid_next;
      out_gray_reg  <= out_gray_next;
      out_id_reg    <= out_id_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    out_valid_next = out_valid_reg;
    out_gray_next  = out_gray_reg;
    out_id_next    = out_id_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          out_gray_next  = grant_gray;
          out_id_next    = grant_id;
          out_valid_next = 1'b1;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        // Result and ID stay put until the consumer takes them.
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          ptr_next       = ptr_after;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_gray  = out_gray_reg;
  assign bus.out_id    = out_id_reg;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter
//
// Drives gray_conv_arbiter through directed scenarios and random traffic.
// A transaction-level model (pointer, held result, arithmetic Gray code)
// predicts req_ready and the result port every cycle. Inputs change just
// after the falling edge; outputs are sampled 1 ns later.
module tb_gray_conv_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_conv_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  gray_conv_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_known = 1'b0;
  bit m_valid = 1'b0;
  int m_ptr   = 0;
  int m_gray  = 0;
  int m_id    = 0;
  int waits [N];

  int          ids [$];
  int          exp_ids [6] = '{0, 1, 2, 3, 0, 1};
  logic [3:0]  gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, check, advance the model across the edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic ordy, input logic r);
    logic [N-1:0] exp_ready;
    int w;
    int seen;
    rst           = r;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = ordy;
    #1;
    w = winner(v, m_ptr);
    exp_ready = '0;
    if (!r && m_known && !m_valid && w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    if (m_known) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_gray", 32'(bus.out_gray), 32'(m_gray));
      chk("out_id", 32'(bus.out_id), 32'(m_id));
    end
    // Fairness, judged from the grants the DUT actually issues.
    seen = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) seen = i;
    if (seen >= 0) begin
      chk("fairness", 32'(waits[seen] <= N - 1), 32'd1);
      for (int i = 0; i < N; i++) if (i != seen && v[i]) waits[i]++;
      waits[seen] = 0;
    end
    for (int i = 0; i < N; i++) if (!v[i] || r) waits[i] = 0;
    // Model update for the coming edge
    if (r) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_ptr   = 0;
      m_gray  = 0;
      m_id    = 0;
    end else if (!m_valid && w >= 0) begin
      m_gray  = gray_of(int'(d[w*W +: W]));
      m_id    = w;
      m_valid = 1'b1;
    end else if (m_valid && ordy) begin
      $display("txn id=%0d gray=%h", m_id, m_gray[W-1:0]);
      m_valid = 1'b0;
      m_ptr   = (m_id + 1) % N;
    end
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    @(negedge clk);

    // Reset held two cycles with every requester asking
    cycle(4'hF, 16'hFFFF, 1'b1, 1'b1);
    cycle(4'hF, 16'hFFFF, 1'b1, 1'b1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_gray", 32'(bus.out_gray), 32'd0);
    chk("rst_id", 32'(bus.out_id), 32'd0);

    // Single request on requester 2, data 1011
    cycle(4'b0100, 16'h0B00, 1'b1, 1'b0);
    chk("single_busy_ready", 32'(bus.req_ready), 32'd0);
    chk("single_valid", 32'(bus.out_valid), 32'd1);
    chk("single_gray", 32'(bus.out_gray), 32'hE);
    chk("single_id", 32'(bus.out_id), 32'd2);
    cycle(4'b0000, 16'h0000, 1'b1, 1'b0);
    chk("single_done", 32'(bus.out_valid), 32'd0);

    // Round-robin with everyone requesting
    cycle(4'b0000, 16'h0000, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      cycle(4'hF, 16'h4321, 1'b1, 1'b0);
      if (bus.out_valid) ids.push_back(int'(bus.out_id));
    end
    chk("rr_count", 32'(ids.size()), 32'd6);
    for (int i = 0; i < 6 && i < ids.size(); i++) chk("rr_order", 32'(ids[i]), 32'(exp_ids[i]));

    // Backpressure on requester 1, data 0101
    cycle(4'b0000, 16'h0000, 1'b1, 1'b1);
    cycle(4'b0010, 16'h0050, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_gray", 32'(bus.out_gray), 32'h7);
      chk("bp_id", 32'(bus.out_id), 32'd1);
      cycle(4'hF, 16'hFFFF, 1'b0, 1'b0);
    end
    cycle(4'b0000, 16'h0000, 1'b1, 1'b0);
    chk("bp_release", 32'(bus.out_valid), 32'd0);

    // Every 4-bit value through requester 0
    for (int b = 0; b < 16; b++) begin
      cycle(4'b0001, 16'(b), 1'b1, 1'b0);
      chk("conv", 32'(bus.out_gray), 32'(gray_tab[b]));
      cycle(4'b0000, 16'h0000, 1'b1, 1'b0);
    end

    // Reset while a result is pending
    cycle(4'b0001, 16'h0005, 1'b0, 1'b0);
    cycle(4'b0000, 16'h0000, 1'b0, 1'b0);
    chk("rb_pending", 32'(bus.out_valid), 32'd1);
    cycle(4'b0000, 16'h0000, 1'b0, 1'b1);
    chk("rb_dropped", 32'(bus.out_valid), 32'd0);
    rst           = 1'b0;
    bus.req_valid = 4'b1100;
    #1;
    chk("rb_grant", 32'(bus.req_ready), 32'b0100);
    cycle(4'b1100, 16'h0000, 1'b1, 1'b0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      cycle(4'($urandom), 16'($urandom), ($urandom_range(3) != 0),
            ($urandom_range(63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
